alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue controller that sits between the instruction decode/execute control and the ALU, acting as the initiator for the ALU's operand/control interface. It accepts one operation per valid/ready handshake, drives operands and the 2-bit ALU control, and for modular exponentiation clears the engine and waits for its multi-cycle finish flag. It then returns the captured result and zero flag through a valid/ready response port. Single-cycle add/sub and multi-cycle mod-exp therefore present one uniform, back-pressurable interface to the pipeline.

## Interface
- ARQ, 16, data width of operands and result
- TIMEOUT_CYCLES, 4096, mod-exp watchdog limit; used only with MODEXP_TIMEOUT_EN
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  controller can accept request
- req_op  in  2  00 add, 01 sub, 10 mod-exp, 11 invalid
- req_a, req_b, req_c  in  ARQ each  operands; mod-exp: base, exponent, modulus
- alu_data1, alu_data2, alu_data3  out  ARQ each  registered operands to ALU
- alu_ctrl  out  2  registered ALU control
- modexp_rst  out  1  clear pulse to mod-exp engine
- alu_result  in  ARQ  ALU result
- alu_z  in  1  ALU zero flag
- alu_mod_fin  in  1  mod-exp done flag, level
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  ARQ  captured result
- rsp_z  out  1  captured zero flag
- rsp_err  out  1  invalid op, or timeout when enabled

## Operation
- States: IDLE, DRIVE, MX_CLR, MX_RUN, RESP.
- IDLE: req_ready=1. On req_valid, register req_a/b/c into alu_data1/2/3 and req_op into alu_ctrl.
  - op 00/01 -> DRIVE.
  - op 10 -> MX_CLR.
  - op 11 -> RESP with rsp_result=0, rsp_z=1, rsp_err=1. ALU is not driven: alu_ctrl keeps its previous value.
- DRIVE: one cycle. Capture alu_result and alu_z, rsp_err=0, then go to RESP.
- MX_CLR: modexp_rst=1 for exactly one cycle. alu_mod_fin is ignored here, because it may be stale from a prior run. Then go to MX_RUN.
- MX_RUN: wait. On the first cycle alu_mod_fin=1, capture alu_result and alu_z, rsp_err=0, then go to RESP.
- RESP: rsp_valid=1. rsp_result, rsp_z and rsp_err are held stable until rsp_ready=1, then go to IDLE.
- req_ready=0 in every state except IDLE. There is no request queuing.
- Operand and control registers hold their values from acceptance until the next acceptance.
- Reset (any state, including mid mod-exp):
  - state=IDLE.
  - All registered outputs are 0: alu_data*, alu_ctrl, rsp_valid, rsp_result, rsp_z, rsp_err.
  - req_ready=0 while rst is high and 1 after release.
  - modexp_rst=1 while rst is high.
- A pending response is discarded on reset.

## Timing
- Cycle numbers count from the acceptance edge, cycle 0.
- Add/sub:
  - operands are on the ALU during cycle 1;
  - capture happens at the end of cycle 1;
  - rsp_valid rises in cycle 2.
  - Minimum request-to-request spacing is 3 cycles when rsp_ready is held at 1.
- Mod-exp:
  - modexp_rst is high in cycle 1;
  - MX_RUN begins in cycle 2;
  - if alu_mod_fin is first seen high in cycle N (N≥2), rsp_valid rises in cycle N+1.
- Invalid op: rsp_valid rises in cycle 1.
- Response handshake completes on the edge where rsp_valid and rsp_ready are both 1. req_ready rises in the following cycle.
- A request presented while the controller is busy is not sampled. It must be held by the requester.

## Configuration
- MODEXP_TIMEOUT_EN defined:
  - a counter clears on entry to MX_RUN and increments each MX_RUN cycle;
  - if it reaches TIMEOUT_CYCLES without alu_mod_fin, go to RESP with rsp_result=0, rsp_z=0, rsp_err=1;
  - if alu_mod_fin is seen on the same cycle the limit is reached, it wins and the response is normal.
- MODEXP_TIMEOUT_EN undefined: no counter. MX_RUN waits indefinitely, and rsp_err is set only for op 11.

## Test plan
- Add: op=00, a=0x0005, b=0x0003, ALU returns 0x0008 -> rsp_valid in cycle 2, rsp_result=0x0008, rsp_z=0, rsp_err=0.
- Sub to zero: op=01, a=b=0x1234, ALU returns 0 with z=1 -> rsp_result=0x0000, rsp_z=1. With rsp_ready held low for 5 cycles, the response stays stable and req_ready stays 0.
- Mod-exp: op=10, a=3, b=5, c=7 -> modexp_rst high only in cycle 1. Model asserts alu_mod_fin in cycle 20 with result 5, and additionally holds alu_mod_fin high during cycle 1; the cycle-1 assertion is ignored. Response: rsp_valid in cycle 21, rsp_result=0x0005.
- Invalid op: op=11 -> rsp_valid in cycle 1, rsp_err=1, rsp_result=0, rsp_z=1, alu_ctrl unchanged.
- Reset mid mod-exp: assert rst in cycle 10 of MX_RUN -> immediately rsp_valid=0, alu_ctrl=00, modexp_rst=1. After release, req_ready=1 and the next add completes normally.
- Timeout (MODEXP_TIMEOUT_EN, TIMEOUT_CYCLES=16): mod-exp with alu_mod_fin never asserted -> rsp_valid in cycle 19, rsp_err=1, rsp_result=0.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// alu_issue_ctrl_if : request, ALU-control and response bundle for alu_issue_ctrl
// Rev 1.0
// ============================================================================

interface alu_issue_ctrl_if #(
  parameter int ARQ = 16
);
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_op;
  logic [ARQ-1:0] req_a;
  logic [ARQ-1:0] req_b;
  logic [ARQ-1:0] req_c;

  logic [ARQ-1:0] alu_data1;
  logic [ARQ-1:0] alu_data2;
  logic [ARQ-1:0] alu_data3;
  logic [1:0]     alu_ctrl;
  logic           modexp_rst;
  logic [ARQ-1:0] alu_result;
  logic           alu_z;
  logic           alu_mod_fin;

  logic           rsp_valid;
  logic           rsp_ready;
  logic [ARQ-1:0] rsp_result;
  logic           rsp_z;
  logic           rsp_err;

  // Controller side: initiator toward the ALU, target toward the pipeline
  modport master (
    input  req_valid, req_op, req_a, req_b, req_c,
    input  alu_result, alu_z, alu_mod_fin,
    input  rsp_ready,
    output req_ready,
    output alu_data1, alu_data2, alu_data3, alu_ctrl, modexp_rst,
    output rsp_valid, rsp_result, rsp_z, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, req_c,
    output alu_result, alu_z, alu_mod_fin,
    output rsp_ready,
    input  req_ready,
    input  alu_data1, alu_data2, alu_data3, alu_ctrl, modexp_rst,
    input  rsp_valid, rsp_result, rsp_z, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// alu_issue_ctrl : issues add/sub/mod-exp to the ALU, returns result via rsp port
// Optional mod-exp watchdog: define MODEXP_TIMEOUT_EN.          Rev 1.0
// ============================================================================

module alu_issue_ctrl #(
  parameter int ARQ            = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  wire logic        clk,
  input  wire logic        rst,
  alu_issue_ctrl_if.master bus
);

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_MX  = 2'b10;
  localparam logic [1:0] c_OP_INV = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_MX_CLR = 3'd2,
    S_MX_RUN = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [ARQ-1:0] r_data1;
  logic [ARQ-1:0] r_data2;
  logic [ARQ-1:0] r_data3;
  logic [1:0]     r_ctrl;
  logic [ARQ-1:0] r_result;
  logic           r_z;
  logic           r_err;
  logic           r_rsp_valid;
  logic           w_accept;
  logic           w_capture;
  logic           w_tmo;
  logic           w_req_ready;
  logic           w_modexp_rst;

  assign w_accept  = (r_state == S_IDLE) && bus.req_valid;
  assign w_capture = (r_state == S_DRIVE) ||
                     ((r_state == S_MX_RUN) && bus.alu_mod_fin);

`ifdef MODEXP_TIMEOUT_EN
  localparam int             c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

  logic [c_CNT_W-1:0] r_cnt;

  // Cleared during MX_CLR so the first MX_RUN cycle sees zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == S_MX_CLR) begin
      r_cnt <= '0;
    end else if ((r_state == S_MX_RUN) && (r_cnt != c_LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tmo = (r_state == S_MX_RUN) && !bus.alu_mod_fin && (r_cnt == c_LIMIT);
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_req_ready  = (r_state == S_IDLE) && !rst;
    w_modexp_rst = rst || (r_state == S_MX_CLR);
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            c_OP_ADD, c_OP_SUB: w_next = S_DRIVE;
            c_OP_MX:            w_next = S_MX_CLR;
            default:            w_next = S_RESP;
          endcase
        end
      end
      S_DRIVE:  w_next = S_RESP;
      S_MX_CLR: w_next = S_MX_RUN;
      S_MX_RUN: begin
        if (bus.alu_mod_fin || w_tmo) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data1     <= '0;
      r_data2     <= '0;
      r_data3     <= '0;
      r_ctrl      <= '0;
      r_result    <= '0;
      r_z         <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= (w_next == S_RESP);
      if (w_accept) begin
        r_data1 <= bus.req_a;
        r_data2 <= bus.req_b;
        r_data3 <= bus.req_c;
        // An invalid op never reaches the ALU, so its control is left alone
        if (bus.req_op != c_OP_INV) begin
          r_ctrl <= bus.req_op;
        end
      end
      if (w_capture) begin
        r_result <= bus.alu_result;
        r_z      <= bus.alu_z;
        r_err    <= 1'b0;
      end else if (w_accept && (bus.req_op == c_OP_INV)) begin
        r_result <= '0;
        r_z      <= 1'b1;
        r_err    <= 1'b1;
      end else if (w_tmo) begin
        r_result <= '0;
        r_z      <= 1'b0;
        r_err    <= 1'b1;
      end
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.modexp_rst = w_modexp_rst;
  assign bus.alu_data1  = r_data1;
  assign bus.alu_data2  = r_data2;
  assign bus.alu_data3  = r_data3;
  assign bus.alu_ctrl   = r_ctrl;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.rsp_z      = r_z;
  assign bus.rsp_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_issue_ctrl : scoreboard bench for alu_issue_ctrl with a small ALU model
// Rev 1.0
// ============================================================================

module tb_alu_issue_ctrl;

  localparam int ARQ = 16;
  localparam int TMO = 16;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc    = 0;
  exp_t sb[$];

  logic [15:0] mx_res;
  logic        mx_fin;
  logic [15:0] alu_model;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_ctrl_if #(.ARQ(ARQ)) bus ();

  alu_issue_ctrl #(.ARQ(ARQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU behaviour: add/sub combinational, mod-exp result supplied by the test
  always_comb begin
    alu_model = mx_res;
    case (bus.alu_ctrl)
      2'b00:   alu_model = bus.alu_data1 + bus.alu_data2;
      2'b01:   alu_model = bus.alu_data1 - bus.alu_data2;
      default: alu_model = mx_res;
    endcase
  end
  assign bus.alu_result  = alu_model;
  assign bus.alu_z       = (alu_model == 16'h0000);
  assign bus.alu_mod_fin = mx_fin;

  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c);
    int n;
    n = 0;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_c     = c;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_accept: req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    acc = cyc - 1;
  endtask

  task automatic wait_rsp(input int exp_lat, input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!bus.rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || (cyc - acc) != exp_lat) begin
      errors++;
      $display("FAIL %s_latency: rsp_valid=%b cycle=%0d required cycle=%0d",
               tag, bus.rsp_valid, cyc - acc, exp_lat);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_rsp: response with empty scoreboard", tag);
    end else begin
      e = sb.pop_front();
      if ({bus.rsp_result, bus.rsp_z, bus.rsp_err} !== {e.res, e.z, e.err}) begin
        errors++;
        $display("FAIL %s_rsp: result=%h z=%b err=%b required result=%h z=%b err=%b",
                 tag, bus.rsp_result, bus.rsp_z, bus.rsp_err, e.res, e.z, e.err);
      end
    end
  endtask

  task automatic finish_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake: req_ready=%b rsp_valid=%b required 1 0",
               tag, bus.req_ready, bus.rsp_valid);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.modexp_rst, bus.rsp_valid, bus.alu_ctrl, bus.alu_data1,
         bus.rsp_result, bus.rsp_z, bus.rsp_err} !== {1'b0, 1'b1, 1'b0, 2'b00, 16'h0, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: ready=%b mxrst=%b valid=%b ctrl=%b d1=%h res=%h z=%b err=%b required 0 1 0 00 0 0 0 0",
               bus.req_ready, bus.modexp_rst, bus.rsp_valid, bus.alu_ctrl, bus.alu_data1,
               bus.rsp_result, bus.rsp_z, bus.rsp_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.modexp_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: req_ready=%b modexp_rst=%b required 1 0",
               bus.req_ready, bus.modexp_rst);
    end
  endtask

  task automatic test_add();
    sb.push_back('{16'h0008, 1'b0, 1'b0});
    send(2'b00, 16'h0005, 16'h0003, 16'h0000);
    checks++;
    if ({bus.alu_data1, bus.alu_data2, bus.alu_ctrl, bus.modexp_rst, bus.rsp_valid}
        !== {16'h0005, 16'h0003, 2'b00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_drive: d1=%h d2=%h ctrl=%b mxrst=%b valid=%b required 0005 0003 00 0 0",
               bus.alu_data1, bus.alu_data2, bus.alu_ctrl, bus.modexp_rst, bus.rsp_valid);
    end
    wait_rsp(2, "add");
    finish_rsp("add");
  endtask

  task automatic test_sub_stall();
    bus.rsp_ready = 1'b0;
    sb.push_back('{16'h0000, 1'b1, 1'b0});
    send(2'b01, 16'h1234, 16'h1234, 16'h0000);
    wait_rsp(2, "sub");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_z, bus.rsp_err}
          !== {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL sub_stall%0d: valid=%b ready=%b res=%h z=%b err=%b required 1 0 0000 1 0",
                 i, bus.rsp_valid, bus.req_ready, bus.rsp_result, bus.rsp_z, bus.rsp_err);
      end
    end
    finish_rsp("sub");
  endtask

  task automatic test_modexp(input int fin_cyc, input logic [15:0] res, input string tag);
    sb.push_back('{res, (res == 16'h0000), 1'b0});
    send(2'b10, 16'h0003, 16'h0005, 16'h0007);
    mx_res = 16'hBEEF;
    mx_fin = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.modexp_rst, bus.alu_ctrl, bus.alu_data1, bus.alu_data2, bus.alu_data3}
        !== {1'b1, 2'b10, 16'h0003, 16'h0005, 16'h0007}) begin
      errors++;
      $display("FAIL %s_clr: mxrst=%b ctrl=%b d=%h %h %h required 1 10 0003 0005 0007",
               tag, bus.modexp_rst, bus.alu_ctrl, bus.alu_data1, bus.alu_data2, bus.alu_data3);
    end
    @(posedge clk);
    #1;
    mx_fin = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.modexp_rst !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_run: modexp_rst=%b rsp_valid=%b required 0 0",
               tag, bus.modexp_rst, bus.rsp_valid);
    end
    repeat (fin_cyc - 2) @(posedge clk);
    #1;
    mx_res = res;
    mx_fin = 1'b1;
    wait_rsp(fin_cyc + 1, tag);
    mx_fin = 1'b0;
    finish_rsp(tag);
  endtask

  task automatic test_invalid();
    sb.push_back('{16'h0000, 1'b1, 1'b1});
    send(2'b11, 16'hAAAA, 16'h5555, 16'h0000);
    checks++;
    if (bus.alu_ctrl !== 2'b10 || bus.alu_data1 !== 16'hAAAA) begin
      errors++;
      $display("FAIL invalid_ctrl: alu_ctrl=%b d1=%h required 10 aaaa",
               bus.alu_ctrl, bus.alu_data1);
    end
    wait_rsp(1, "invalid");
    finish_rsp("invalid");
  endtask

  task automatic test_back_to_back();
    int a0;
    sb.push_back('{16'h0123, 1'b0, 1'b0});
    send(2'b00, 16'h0100, 16'h0023, 16'h0000);
    wait_rsp(2, "b2b0");
    a0 = acc;
    sb.push_back('{16'h0000, 1'b1, 1'b0});
    send(2'b00, 16'hFFFF, 16'h0001, 16'h0000);
    checks++;
    if (acc - a0 != 3) begin
      errors++;
      $display("FAIL b2b_spacing: spacing=%0d required 3", acc - a0);
    end
    wait_rsp(2, "b2b1");
    finish_rsp("b2b");
  endtask

  task automatic test_reset_midmx();
    mx_fin = 1'b0;
    send(2'b10, 16'h0002, 16'h0003, 16'h0005);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.alu_ctrl, bus.modexp_rst, bus.req_ready, bus.alu_data1}
        !== {1'b0, 2'b00, 1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL midmx_reset: valid=%b ctrl=%b mxrst=%b ready=%b d1=%h required 0 00 1 0 0000",
               bus.rsp_valid, bus.alu_ctrl, bus.modexp_rst, bus.req_ready, bus.alu_data1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.modexp_rst !== 1'b0) begin
      errors++;
      $display("FAIL midmx_release: req_ready=%b modexp_rst=%b required 1 0",
               bus.req_ready, bus.modexp_rst);
    end
    sb.push_back('{16'h0010, 1'b0, 1'b0});
    send(2'b00, 16'h0007, 16'h0009, 16'h0000);
    wait_rsp(2, "post_rst");
    finish_rsp("post_rst");
  endtask

`ifdef MODEXP_TIMEOUT_EN
  task automatic test_timeout();
    mx_fin = 1'b0;
    sb.push_back('{16'h0000, 1'b0, 1'b1});
    send(2'b10, 16'h0001, 16'h0001, 16'h0003);
    wait_rsp(TMO + 3, "timeout");
    finish_rsp("timeout");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_c     = '0;
    bus.rsp_ready = 1'b1;
    mx_fin        = 1'b0;
    mx_res        = '0;

    test_reset();
    test_add();
    test_sub_stall();
`ifdef MODEXP_TIMEOUT_EN
    test_modexp(12, 16'h0005, "modexp");
    test_modexp(TMO + 2, 16'h0009, "mx_limit");
`else
    test_modexp(20, 16'h0005, "modexp");
`endif
    test_invalid();
    test_back_to_back();
    test_reset_midmx();
`ifdef MODEXP_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
